// File: rtl/pipe_register_if.sv
// Valid/ready handshake bundle for the elastic pipeline register.
// The producer side is in_*, the consumer side is out_*.
interface pipe_register_if #(
   parameter int WIDTH = 8
) ();
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;

   // The environment drives items in and accepts items out
   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  out_data,
      input  out_valid,
      output out_ready
   );

   // The pipeline register accepts items in and presents items out
   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output out_data,
      output out_valid,
      input  out_ready
   );
endinterface

// File: rtl/pipe_register.sv
// Elastic pipeline register: STAGES x WIDTH chain with valid/ready at both ends,
// bubble collapsing, synchronous flush and a registered occupancy count.
module pipe_register #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 3
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            flush,
   pipe_register_if.slave                  bus,
   output logic [$clog2(STAGES + 1) - 1:0] count
);

   localparam int CW = $clog2(STAGES + 1);

   logic [WIDTH-1:0]  data_q [STAGES];
   logic [WIDTH-1:0]  data_d [STAGES];
   logic [STAGES-1:0] valid_q;
   logic [STAGES-1:0] valid_d;
   logic [CW-1:0]     count_q;
   logic [CW-1:0]     count_d;
   logic [STAGES-1:0] stageAdv;
   logic              inReady;
   logic              inXfer;
   logic              outXfer;

   // A stage can move only if the consumer takes the head or some stage at or
   // beyond it is empty; computed per stage to keep the ready chain loop-free.
   always_comb begin
      logic allFull;
      allFull  = 1'b1;
      stageAdv = '0;
      for (int i = 0; i < STAGES; i++) begin
         allFull = 1'b1;
         for (int j = i; j < STAGES; j++) begin
            allFull = allFull & valid_q[j];
         end
         stageAdv[i] = bus.out_ready || !allFull;
      end
   end

   assign inReady = stageAdv[0] && !flush;
   assign inXfer  = bus.in_valid && inReady;
   assign outXfer = valid_q[STAGES-1] && bus.out_ready;

   // Every advancing stage pulls from its upstream neighbour; stage 0 pulls from the input
   always_comb begin
      valid_d = valid_q;
      for (int i = 0; i < STAGES; i++) begin
         data_d[i] = data_q[i];
      end
      if (stageAdv[0]) begin
         data_d[0]  = bus.in_data;
         valid_d[0] = inXfer;
      end
      for (int i = 1; i < STAGES; i++) begin
         if (stageAdv[i]) begin
            data_d[i]  = data_q[i-1];
            valid_d[i] = valid_q[i-1];
         end
      end
   end

   // Occupancy tracks transfers directly rather than recounting the valid bits
   always_comb begin
      count_d = count_q + CW'(inXfer) - CW'(outXfer);
   end

   // Flush empties the valid bits but leaves the data registers untouched
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         count_q <= '0;
         for (int i = 0; i < STAGES; i++) begin
            data_q[i] <= '0;
         end
      end else if (flush) begin
         valid_q <= '0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         count_q <= count_d;
         for (int i = 0; i < STAGES; i++) begin
            data_q[i] <= data_d[i];
         end
      end
   end

   assign bus.in_ready  = inReady;
   assign bus.out_data  = data_q[STAGES-1];
   assign bus.out_valid = valid_q[STAGES-1];
   assign count         = count_q;

endmodule

// File: tb/tb_pipe_register.sv
// Scoreboard bench for pipe_register: a 3-stage and a 1-stage instance share
// identical stimulus, each with its own FIFO of expected items.
module tb_pipe_register;

   logic clk;
   logic rst;
   logic flush;
   logic [1:0] countA;
   logic [0:0] countB;

   int compareCount = 0;
   int failCount    = 0;

   logic [7:0] sbA[$];
   logic [7:0] sbB[$];

   pipe_register_if #(.WIDTH(8)) busA ();
   pipe_register_if #(.WIDTH(8)) busB ();

   pipe_register #(.WIDTH(8), .STAGES(3)) dutA (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (busA),
      .count (countA)
   );

   pipe_register #(.WIDTH(8), .STAGES(1)) dutB (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (busB),
      .count (countB)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of stimulus to both instances, check handshakes before the edge
   // against the occupancy model, and check count/valid after the edge.
   task automatic applyStimulus(input logic iv, input logic [7:0] id, input logic ordy,
                                input logic fl, input logic r);
      logic expRdyA;
      logic expRdyB;
      logic [7:0] expData;
      busA.in_valid  = iv;
      busA.in_data   = id;
      busA.out_ready = ordy;
      busB.in_valid  = iv;
      busB.in_data   = id;
      busB.out_ready = ordy;
      flush          = fl;
      rst            = r;
      #2;
      if (!r) begin
         expRdyA = !fl && (sbA.size() < 3 || ordy);
         expRdyB = !fl && (sbB.size() < 1 || ordy);
         checkOutput("A.in_ready", {31'd0, busA.in_ready}, {31'd0, expRdyA});
         checkOutput("B.in_ready", {31'd0, busB.in_ready}, {31'd0, expRdyB});
         if (busA.out_valid && ordy) begin
            if (sbA.size() > 0) begin
               expData = sbA.pop_front();
               checkOutput("A.out_data", {24'd0, busA.out_data}, {24'd0, expData});
            end else begin
               checkOutput("A.out_extra", {31'd0, busA.out_valid}, 32'd0);
            end
         end
         if (busB.out_valid && ordy) begin
            if (sbB.size() > 0) begin
               expData = sbB.pop_front();
               checkOutput("B.out_data", {24'd0, busB.out_data}, {24'd0, expData});
            end else begin
               checkOutput("B.out_extra", {31'd0, busB.out_valid}, 32'd0);
            end
         end
         if (fl) begin
            sbA.delete();
            sbB.delete();
         end else begin
            if (iv && expRdyA) sbA.push_back(id);
            if (iv && expRdyB) sbB.push_back(id);
         end
      end
      @(posedge clk);
      #1;
      if (r) begin
         sbA.delete();
         sbB.delete();
      end
      checkOutput("A.count", {30'd0, countA}, sbA.size());
      checkOutput("B.count", {31'd0, countB}, sbB.size());
      if (sbA.size() == 0) checkOutput("A.out_valid_empty", {31'd0, busA.out_valid}, 32'd0);
      if (sbB.size() == 0) checkOutput("B.out_valid_empty", {31'd0, busB.out_valid}, 32'd0);
      @(negedge clk);
   endtask

   task automatic drainAll();
      for (int n = 0; n < 12; n++) begin
         if (sbA.size() == 0 && sbB.size() == 0) break;
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      end
      checkOutput("A.drained", sbA.size(), 32'd0);
      checkOutput("B.drained", sbB.size(), 32'd0);
   endtask

   initial begin
      // Reset held three cycles with a valid item waiting
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0, 1'b1);
         checkOutput("rst.out_valid", {31'd0, busA.out_valid}, 32'd0);
         checkOutput("rst.out_data", {24'd0, busA.out_data}, 32'd0);
         checkOutput("rst.count", {30'd0, countA}, 32'd0);
         checkOutput("rst.in_ready", {31'd0, busA.in_ready}, 32'd1);
      end
      applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
      checkOutput("rel.countA", {30'd0, countA}, 32'd1);
      checkOutput("rel.B.out_data", {24'd0, busB.out_data}, 32'hAA);
      drainAll();

      // Streaming at full throughput
      for (int k = 1; k <= 16; k++) begin
         applyStimulus(1'b1, 8'(k), 1'b1, 1'b0, 1'b0);
         if (k == 1) begin
            checkOutput("strB.out_valid", {31'd0, busB.out_valid}, 32'd1);
            checkOutput("strB.out_data", {24'd0, busB.out_data}, 32'h01);
         end
         if (k == 3) begin
            checkOutput("strA.out_valid", {31'd0, busA.out_valid}, 32'd1);
            checkOutput("strA.out_data", {24'd0, busA.out_data}, 32'h01);
         end
         if (k >= 3) checkOutput("strA.count", {30'd0, countA}, 32'd3);
      end
      drainAll();

      // Back-pressure: fourth item held off until the consumer is ready
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b1, 8'hA0 + 8'(k), 1'b0, 1'b0, 1'b0);
      end
      checkOutput("bp.in_ready", {31'd0, busA.in_ready}, 32'd0);
      checkOutput("bp.count", {30'd0, countA}, 32'd3);
      checkOutput("bp.out_data", {24'd0, busA.out_data}, 32'hA0);
      applyStimulus(1'b1, 8'hA3, 1'b1, 1'b0, 1'b0);
      checkOutput("bp.count_full_xfer", {30'd0, countA}, 32'd3);
      drainAll();

      // Bubble collapse under back-pressure
      applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      checkOutput("bub.count", {30'd0, countA}, 32'd2);
      checkOutput("bub.head", {24'd0, busA.out_data}, 32'h11);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checkOutput("bub.next_valid", {31'd0, busA.out_valid}, 32'd1);
      checkOutput("bub.next_data", {24'd0, busA.out_data}, 32'h22);
      drainAll();

      // Flush with the head delivered on the flush edge
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 8'hB0 + 8'(k), 1'b0, 1'b0, 1'b0);
      end
      checkOutput("fl.count_before", {30'd0, countA}, 32'd3);
      applyStimulus(1'b1, 8'hCC, 1'b1, 1'b1, 1'b0);
      checkOutput("fl.in_ready", {31'd0, busA.in_ready}, 32'd0);
      checkOutput("fl.count", {30'd0, countA}, 32'd0);
      checkOutput("fl.out_valid", {31'd0, busA.out_valid}, 32'd0);
      applyStimulus(1'b1, 8'hCD, 1'b1, 1'b0, 1'b0);
      checkOutput("fl.resume", {30'd0, countA}, 32'd1);
      drainAll();

      // Simultaneous in/out transfer while full
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 8'hC0 + 8'(k), 1'b0, 1'b0, 1'b0);
      end
      for (int k = 3; k < 8; k++) begin
         applyStimulus(1'b1, 8'hC0 + 8'(k), 1'b1, 1'b0, 1'b0);
         checkOutput("full.count", {30'd0, countA}, 32'd3);
      end
      drainAll();

      // Reset mid-stream discards everything in flight
      applyStimulus(1'b1, 8'hD0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'hD1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'hD2, 1'b1, 1'b0, 1'b1);
      checkOutput("mrst.count", {30'd0, countA}, 32'd0);
      checkOutput("mrst.out_valid", {31'd0, busB.out_valid}, 32'd0);
      applyStimulus(1'b1, 8'hD3, 1'b1, 1'b0, 1'b0);
      drainAll();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule

// File: doc/pipe_register.md
# pipe_register

Parametrised elastic pipeline register: a chain of STAGES registers, each WIDTH bits wide, with a valid/ready handshake at both ends, per-stage valid bits, synchronous flush and an occupancy count. It replaces the fixed 4-bit free-running register wherever a datapath must be retimed by several cycles while tolerating downstream back-pressure. It sits between producer and consumer blocks on a single clock domain.

## Interface
- WIDTH, 8, data width in bits (≥1)
- STAGES, 3, number of register stages (≥1)
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous discard of all stored items
- in_data  input  WIDTH  producer data
- in_valid  input  1  producer has data
- in_ready  output  1  block accepts in_data this cycle
- out_data  output  WIDTH  data of last stage
- out_valid  output  1  last stage holds a valid item
- out_ready  input  1  consumer accepts out_data this cycle
- count  output  $clog2(STAGES+1)  number of valid items held, 0..STAGES

## Operation
- Storage: stage i (0 = input side, STAGES-1 = output side) holds data[i] and v[i].
- Transfer rules: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Advance: the last stage advances when out_ready || !v[STAGES-1]; stage i (i < STAGES-1) advances when !v[i] || stage i+1 advances. This is a combinational ready chain; no bubbles are required for full throughput.
- in_ready = (stage 0 advances) && !flush.
- On an advancing edge, stage 0 loads in_data and v[0] <= input transfer. Stage i>0 loads data[i-1] and v[i] <= v[i-1]. A non-advancing stage holds its data and valid.
- out_data = data[STAGES-1] and out_valid = v[STAGES-1]. Both are registered outputs with no combinational path from in_*.
- count: registered. Next value = count + input transfer − output transfer. It always equals the popcount of v.
- flush: on the edge where flush=1, all v[i] <= 0 and count <= 0. Data registers are unchanged.
  - in_ready is forced to 0, so no input transfer occurs.
  - An output transfer in the same cycle counts as delivered. All other items are discarded.
- Priority: rst > flush > normal operation.
- Order is strictly FIFO. No item is duplicated or dropped except by flush or rst.

## Timing
- Reset values (after the rst edge): all v[i]=0, all data[i]=0, out_valid=0, out_data=0, count=0.
- in_ready is combinational: it is 1 during rst-held cycles unless flush=1, but nothing is stored while rst=1.
- Latency, no stalls: an item accepted at edge t is in stage k after edge t+k. out_valid=1 with that item after edge t+STAGES−1. For STAGES=1 this is immediately after the accept edge.
- Throughput: one item per cycle sustained while out_ready=1.
- Full: count=STAGES and out_ready=0 gives in_ready=0. Full with out_ready=1 gives in_ready=1, with simultaneous in and out transfer and count unchanged.
- Empty: out_valid=0; in_ready=1 (unless flush).
- Bubbles collapse: an empty stage is filled on the next edge regardless of out_ready.
- rst or flush mid-stream: takes effect on that edge. Accepting resumes the following cycle; for flush, in_ready returns with flush=0.
- count width: $clog2(STAGES+1), e.g. 2 bits for STAGES=3. It must never wrap.

## Test plan
- Reset: hold rst for 3 cycles with in_valid=1 and in_data=8'hAA, then release. Required: out_valid=0, count=0 and out_data=0 during reset; first acceptance on the edge after release.
- Streaming (WIDTH=8, STAGES=3): out_ready=1; present 8'h01..8'h10 on consecutive cycles. Required: in_ready=1 throughout; 8'h01 at output after the 3rd accept edge; one item per cycle in order; count steady at 3.
- Back-pressure: out_ready=0; push 8'hA0, 8'hA1, 8'hA2, 8'hA3. Required: in_ready=0 once count=3; 8'hA3 held off. With out_ready=1: outputs A0, A1, A2, A3 in order; count 3→3→…→0.
- Bubble collapse: push 8'h11, idle 2 cycles, push 8'h22, with out_ready=0. Required: both items adjacent at stages 2 and 1; count=2.
- Flush: with 3 items held (B0..B2), out_ready=1 and flush=1 for one cycle. Required: B0 delivered, B1 and B2 discarded; count=0 and out_valid=0 next cycle; in_ready=0 during the flush cycle.
- Simultaneous transfer when full: count=3, in_valid=1 and out_ready=1 for 5 cycles. Required: count stays 3; no loss or duplication.
- Repeat the streaming scenario with STAGES=1.
